// File: rtl/cpu_sensor_pio_in_if.sv
// Avalon-MM slave bus for the sensor input PIO.
// The interrupt line travels with the bus so the HPS side sees one bundle.
interface cpu_sensor_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/cpu_sensor_pio_in.sv
// Sensor/button input PIO: synchronize, debounce, capture edges (W1C)
// and raise a maskable level interrupt on the Avalon-MM lightweight bus.
module cpu_sensor_pio_in #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_port,
    cpu_sensor_pio_in_if.slave bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdmux;
    logic [31:0]      r_readdata;
    logic             w_wr;
    logic             w_rd;

    // Synchronizer chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Debouncer
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
        always_ff @(posedge clk) begin
            if (reset) r_stable <= '0;
            else       r_stable <= w_sync;
        end
    end else begin : g_db
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
        logic [CNT_W-1:0] r_cnt [WIDTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_stable <= '0;
                for (int b = 0; b < WIDTH; b++) r_cnt[b] <= '0;
            end else begin
                for (int b = 0; b < WIDTH; b++) begin
                    if (w_sync[b] == r_stable[b]) begin
                        r_cnt[b] <= '0;
                    end else if (r_cnt[b] == CNT_LAST) begin
                        r_stable[b] <= w_sync[b];
                        r_cnt[b]    <= '0;
                    end else begin
                        r_cnt[b] <= r_cnt[b] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Edge detect on the debounced value
    always_comb begin
        w_rise = r_stable & ~r_stable_d;
        w_fall = ~r_stable & r_stable_d;
        case (EDGE_TYPE)
            1:       w_ev = w_fall;
            2:       w_ev = w_rise | w_fall;
            default: w_ev = w_rise;
        endcase
    end

    assign w_wr  = bus.chipselect & ~bus.write_n;
    assign w_rd  = bus.chipselect & ~bus.read_n;
    assign w_clr = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rdmux = '0;
        case (bus.address)
            2'd0:    w_rdmux[WIDTH-1:0] = r_stable;
            2'd2:    w_rdmux[WIDTH-1:0] = r_irq_mask;
            2'd3:    w_rdmux[WIDTH-1:0] = r_edge_cap;
            default: w_rdmux = '0;
        endcase
    end

    // Register file; a new edge wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d <= '0;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_readdata <= '0;
        end else begin
            r_stable_d <= r_stable;
            if (w_wr && bus.address == 2'd2) r_irq_mask <= bus.writedata[WIDTH-1:0];
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_ev;
            r_readdata <= w_rd ? w_rdmux : 32'h0;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |(r_edge_cap & r_irq_mask);

    if (WIDTH < 32) begin : g_wd_upper
        logic w_unused_wd;
        assign w_unused_wd = ^bus.writedata[31:WIDTH];
    end

endmodule

// File: tb/tb_cpu_sensor_pio_in.sv
// Directed bench: one DUT with the default debounced rising-edge setup,
// a second with any-edge capture and no debouncer.
module tb_cpu_sensor_pio_in;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_a = 4'h0;
    logic [3:0] in_b = 4'h0;
    int         checks = 0;
    int         failures = 0;
    logic [31:0] rd;

    cpu_sensor_pio_in_if bus_a ();
    cpu_sensor_pio_in_if bus_b ();

    cpu_sensor_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_a (
        .clk(clk), .reset(reset), .in_port(in_a), .bus(bus_a.slave)
    );

    cpu_sensor_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut_b (
        .clk(clk), .reset(reset), .in_port(in_b), .bus(bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.chipselect = 1'b0; bus_a.read_n = 1'b1; bus_a.write_n = 1'b1;
        bus_a.address = 2'd0; bus_a.writedata = 32'h0;
    endtask

    task automatic idle_b();
        bus_b.chipselect = 1'b0; bus_b.read_n = 1'b1; bus_b.write_n = 1'b1;
        bus_b.address = 2'd0; bus_b.writedata = 32'h0;
    endtask

    task automatic rd_a(input logic [1:0] a, output logic [31:0] d);
        bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.read_n = 1'b0;
        tick();
        d = bus_a.readdata;
        idle_a();
    endtask

    task automatic wr_a(input logic [1:0] a, input logic [31:0] d);
        bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        tick();
        idle_a();
    endtask

    task automatic rd_b(input logic [1:0] a, output logic [31:0] d);
        bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.read_n = 1'b0;
        tick();
        d = bus_b.readdata;
        idle_b();
    endtask

    task automatic wr_b(input logic [1:0] a, input logic [31:0] d);
        bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        tick();
        idle_b();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (bus_a.readdata !== 32'h0 || bus_a.irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs readdata=%h irq=%b want 0/0", bus_a.readdata, bus_a.irq);
        end
        for (int a = 0; a < 4; a++) begin
            rd_a(2'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL reset_read addr=%0d got=%h want=0", a, rd);
            end
        end
    endtask

    task automatic test_rise_latency();
        in_a = 4'h1;
        bus_a.address = 2'd0; bus_a.chipselect = 1'b1; bus_a.read_n = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (bus_a.readdata !== 32'h0) begin
            failures++;
            $display("FAIL data_early got=%h want=0", bus_a.readdata);
        end
        tick();
        checks++;
        if (bus_a.readdata !== 32'h1) begin
            failures++;
            $display("FAIL data_cycle6 got=%h want=1", bus_a.readdata);
        end
        bus_a.address = 2'd3;
        tick();
        checks++;
        if (bus_a.readdata !== 32'h1 || bus_a.irq !== 1'b0) begin
            failures++;
            $display("FAIL cap_rise cap=%h irq=%b want 1/0", bus_a.readdata, bus_a.irq);
        end
        idle_a();
    endtask

    task automatic test_irq_w1c();
        wr_a(2'd2, 32'h1);
        checks++;
        if (bus_a.irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_mask_set irq=%b want 1", bus_a.irq);
        end
        wr_a(2'd3, 32'h1);
        checks++;
        if (bus_a.irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_after_clr irq=%b want 0", bus_a.irq);
        end
        rd_a(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL cap_cleared got=%h want=0", rd);
        end
        wr_a(2'd0, 32'hF);
        wr_a(2'd1, 32'hF);
        rd_a(2'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL data_write_ignored got=%h want=1", rd);
        end
        rd_a(2'd1, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reserved_read got=%h want=0", rd);
        end
        wr_a(2'd2, 32'hFFFF_FFF1);
        rd_a(2'd2, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL mask_upper_bits got=%h want=1", rd);
        end
    endtask

    task automatic test_debounce();
        in_a = 4'h5;
        for (int i = 0; i < 3; i++) tick();
        in_a = 4'h1;
        for (int i = 0; i < 10; i++) tick();
        rd_a(2'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL glitch_data got=%h want=1", rd);
        end
        rd_a(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL glitch_cap got=%h want=0", rd);
        end
        bus_a.address = 2'd0; bus_a.chipselect = 1'b1; bus_a.read_n = 1'b0;
        in_a = 4'h5;
        for (int i = 0; i < 4; i++) tick();
        in_a = 4'h1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus_a.readdata !== 32'h5) begin
            failures++;
            $display("FAIL pulse_data_high got=%h want=5", bus_a.readdata);
        end
        idle_a();
        for (int i = 0; i < 6; i++) tick();
        rd_a(2'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL pulse_data_low got=%h want=1", rd);
        end
        rd_a(2'd3, rd);
        checks++;
        if (rd !== 32'h4 || bus_a.irq !== 1'b0) begin
            failures++;
            $display("FAIL pulse_cap cap=%h irq=%b want 4/0", rd, bus_a.irq);
        end
        wr_a(2'd3, 32'h4);
    endtask

    task automatic test_set_wins();
        in_a = 4'h3;
        for (int i = 0; i < 6; i++) tick();
        wr_a(2'd3, 32'h2);
        rd_a(2'd3, rd);
        checks++;
        if (rd !== 32'h2 || bus_a.irq !== 1'b0) begin
            failures++;
            $display("FAIL set_wins cap=%h irq=%b want 2/0", rd, bus_a.irq);
        end
        bus_a.address = 2'd3; bus_a.writedata = 32'hF; bus_a.chipselect = 1'b1;
        bus_a.read_n = 1'b0; bus_a.write_n = 1'b0;
        tick();
        checks++;
        if (bus_a.readdata !== 32'h2) begin
            failures++;
            $display("FAIL rdwr_prewrite got=%h want=2", bus_a.readdata);
        end
        idle_a();
        rd_a(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL clear_all got=%h want=0", rd);
        end
    endtask

    task automatic test_any_edge();
        wr_b(2'd2, 32'h8);
        in_b = 4'h8;
        for (int i = 0; i < 3; i++) tick();
        in_b = 4'h0;
        tick();
        checks++;
        if (bus_b.irq !== 1'b1) begin
            failures++;
            $display("FAIL any_rise irq=%b want 1", bus_b.irq);
        end
        wr_b(2'd3, 32'h8);
        checks++;
        if (bus_b.irq !== 1'b0) begin
            failures++;
            $display("FAIL any_clr irq=%b want 0", bus_b.irq);
        end
        tick();
        checks++;
        if (bus_b.irq !== 1'b0) begin
            failures++;
            $display("FAIL any_gap irq=%b want 0", bus_b.irq);
        end
        tick();
        checks++;
        if (bus_b.irq !== 1'b1) begin
            failures++;
            $display("FAIL any_fall irq=%b want 1", bus_b.irq);
        end
        wr_b(2'd2, 32'h0);
        checks++;
        if (bus_b.irq !== 1'b0) begin
            failures++;
            $display("FAIL any_unmask irq=%b want 0", bus_b.irq);
        end
        rd_b(2'd3, rd);
        checks++;
        if (rd !== 32'h8) begin
            failures++;
            $display("FAIL any_cap got=%h want=8", rd);
        end
    endtask

    task automatic test_reset_midway();
        wr_b(2'd2, 32'h8);
        checks++;
        if (bus_b.irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_irq irq=%b want 1", bus_b.irq);
        end
        in_a = 4'h0;
        in_b = 4'h8;
        tick(); tick();
        reset = 1'b1;
        bus_a.address = 2'd2; bus_a.chipselect = 1'b1; bus_a.read_n = 1'b0;
        tick();
        checks++;
        if (bus_a.readdata !== 32'h0 || bus_b.irq !== 1'b0 || bus_a.irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid rd=%h irq_a=%b irq_b=%b want 0/0/0",
                     bus_a.readdata, bus_a.irq, bus_b.irq);
        end
        idle_a();
        in_b = 4'h0;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        for (int a = 0; a < 4; a++) begin
            rd_a(2'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL post_reset_a addr=%0d got=%h want=0", a, rd);
            end
            rd_b(2'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL post_reset_b addr=%0d got=%h want=0", a, rd);
            end
        end
    endtask

    initial begin
        idle_a();
        idle_b();
        test_reset();
        test_rise_latency();
        test_irq_w1c();
        test_debounce();
        test_set_wins();
        test_any_edge();
        test_reset_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
